// File: rtl/clk_div_pkg.sv
// Shared definitions for the divider reconfiguration controller: state
// encoding, default parameter values and a counter sizing helper.
package clk_div_pkg;

    localparam int DEF_WIDTH       = 8;
    localparam int DEF_SETTLE_CYC  = 2;
    localparam int DEF_TIMEOUT_CYC = 512;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_BND = 2'd1,
        ST_APPLY    = 2'd2,
        ST_SETTLE   = 2'd3
    } state_t;

    // Bits needed to hold a count up to max_count, never less than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Falling-edge detector for a slow signal sampled as data on the fast clock:
// one registered sample compared against the current value.
module clk_edge_det
    import clk_div_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic fall
);

    logic sig_q;

    // Remember the previous sample so a 1 -> 0 step can be seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign fall = sig_q & ~sig;

endmodule

// File: rtl/clk_div_ctrl.sv
// Divider reconfiguration controller. Accepts enable/ratio requests, waits
// for a falling boundary of the divided clock when the divider is running,
// applies the new settings, lets them settle and reports completion.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             I_ref_clk,
    input  logic             I_rst,
    input  logic             I_cfg_valid,
    output logic             O_cfg_ready,
    input  logic             I_cfg_en,
    input  logic [WIDTH-1:0] I_cfg_ratio,
    input  logic             I_div_clk,
    output logic             O_div_en,
    output logic [WIDTH-1:0] O_div_ratio,
    output logic             O_busy,
    output logic             O_done,
    output logic             O_cfg_err,
    output logic             O_timeout
);

    localparam int TO_W = cnt_width(TIMEOUT_CYC);
    localparam int ST_W = cnt_width(SETTLE_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    state_t           state;
    state_t           state_next;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_next;
    logic [ST_W-1:0]  st_cnt;
    logic [ST_W-1:0]  st_cnt_next;
    logic             req_en;
    logic [WIDTH-1:0] req_ratio;
    logic             capture;
    logic             load;
    logic             done_next;
    logic             err_next;
    logic             timeout_next;
    logic             div_fall;
    logic             fast_path;

    clk_edge_det u_edge_det (
        .clk  (I_ref_clk),
        .rst  (I_rst),
        .sig  (I_div_clk),
        .fall (div_fall)
    );

    assign O_cfg_ready = (state == ST_IDLE);
    assign O_busy      = (state != ST_IDLE);

    // No boundary wait is needed when the divider is stopped, too fast to
    // glitch, or the request would not change anything.
    assign fast_path = !O_div_en
                    || (O_div_ratio <= WIDTH'(1))
                    || ((I_cfg_en == O_div_en) && (I_cfg_ratio == O_div_ratio));

    // Next state, counter updates and status pulses for the sequencing FSM.
    always_comb begin
        state_next   = state;
        to_cnt_next  = to_cnt;
        st_cnt_next  = st_cnt;
        capture      = 1'b0;
        load         = 1'b0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        timeout_next = 1'b0;
        case (state)
            ST_IDLE: begin
                to_cnt_next = '0;
                st_cnt_next = '0;
                if (I_cfg_valid) begin
                    if (I_cfg_en && (I_cfg_ratio == '0)) begin
                        err_next = 1'b1;
                    end else begin
                        capture    = 1'b1;
                        state_next = fast_path ? ST_APPLY : ST_WAIT_BND;
                    end
                end
            end
            ST_WAIT_BND: begin
                if (div_fall) begin
                    state_next = ST_APPLY;
                end else if (to_cnt >= TO_LAST) begin
                    state_next   = ST_APPLY;
                    timeout_next = 1'b1;
                end else begin
                    to_cnt_next = to_cnt + TO_W'(1);
                end
            end
            ST_APPLY: begin
                load        = 1'b1;
                st_cnt_next = '0;
                state_next  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (st_cnt >= ST_LAST) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    st_cnt_next = st_cnt + ST_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register and the two wait counters.
    always_ff @(posedge I_ref_clk or posedge I_rst) begin
        if (I_rst) begin
            state  <= ST_IDLE;
            to_cnt <= '0;
            st_cnt <= '0;
        end else begin
            state  <= state_next;
            to_cnt <= to_cnt_next;
            st_cnt <= st_cnt_next;
        end
    end

    // Hold the accepted request and drive the divider once it is applied.
    always_ff @(posedge I_ref_clk or posedge I_rst) begin
        if (I_rst) begin
            req_en      <= 1'b0;
            req_ratio   <= '0;
            O_div_en    <= 1'b0;
            O_div_ratio <= WIDTH'(1);
        end else begin
            if (capture) begin
                req_en    <= I_cfg_en;
                req_ratio <= I_cfg_ratio;
            end
            if (load) begin
                O_div_en    <= req_en;
                O_div_ratio <= req_ratio;
            end
        end
    end

    // Registered single-cycle status pulses.
    always_ff @(posedge I_ref_clk or posedge I_rst) begin
        if (I_rst) begin
            O_done    <= 1'b0;
            O_cfg_err <= 1'b0;
            O_timeout <= 1'b0;
        end else begin
            O_done    <= done_next;
            O_cfg_err <= err_next;
            O_timeout <= timeout_next;
        end
    end

endmodule
